// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/ack fetch
// to instruction memory, and handles hazard stalls and ID-stage redirects.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_WR,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        JUMP,
    input  logic [31:0] JUMP_TARGET,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] PC_OUT,
    output logic [31:0] PC_PLUS4_OUT,
    output logic [31:0] INSTR_OUT,
    output logic        INSTR_VALID
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    logic        redirect;
    logic [31:0] redir_target;

    // Branch wins over jump; targets are forced word-aligned.
    always_comb begin
        redirect     = BRANCH_TAKEN | JUMP;
        redir_target = BRANCH_TAKEN ? BRANCH_TARGET : JUMP_TARGET;
        redir_target[1:0] = 2'b00;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redir_pc_d = redir_pc_q;
        buf_d      = buf_q;
        pc_out_d   = pc_out_q;
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        valid_d    = valid_q;

        if (redirect) begin
            instr_d = 32'd0;
            valid_d = 1'b0;
            case (state_q)
                HOLD: begin
                    pc_d    = redir_target;
                    state_d = FETCH;
                end
                default: begin
                    // FETCH and DROP: an in-flight ack lets us jump straight away,
                    // otherwise park the target until the old request completes.
                    if (IMEM_ACK) begin
                        pc_d    = redir_target;
                        state_d = FETCH;
                    end else begin
                        redir_pc_d = redir_target;
                        state_d    = DROP;
                    end
                end
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (IMEM_ACK) begin
                        if (PC_WR) begin
                            instr_d    = IMEM_RDATA;
                            pc_out_d   = pc_q;
                            pc_plus4_d = pc_q + 32'd4;
                            valid_d    = 1'b1;
                            pc_d       = pc_q + 32'd4;
                        end else begin
                            buf_d   = IMEM_RDATA;
                            state_d = HOLD;
                        end
                    end else if (PC_WR) begin
                        instr_d = 32'd0;
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (PC_WR) begin
                        instr_d    = buf_q;
                        pc_out_d   = pc_q;
                        pc_plus4_d = pc_q + 32'd4;
                        valid_d    = 1'b1;
                        pc_d       = pc_q + 32'd4;
                        state_d    = FETCH;
                    end
                end
                DROP: begin
                    instr_d = 32'd0;
                    valid_d = 1'b0;
                    if (IMEM_ACK) begin
                        pc_d    = redir_pc_q;
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            redir_pc_q <= 32'd0;
            buf_q      <= 32'd0;
            pc_out_q   <= 32'd0;
            pc_plus4_q <= 32'd0;
            instr_q    <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redir_pc_q <= redir_pc_d;
            buf_q      <= buf_d;
            pc_out_q   <= pc_out_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    // Request is held off while reset is asserted so an abandoned handshake drops at once.
    assign IMEM_REQ     = rst && (state_q != HOLD);
    assign IMEM_ADDR    = pc_q;
    assign PC_OUT       = pc_out_q;
    assign PC_PLUS4_OUT = pc_plus4_q;
    assign INSTR_OUT    = instr_q;
    assign INSTR_VALID  = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed test-plan scenarios with literal expectations,
// then randomized stall/redirect/ack traffic checked every cycle against a flag-based model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        PC_WR;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        JUMP;
    logic [31:0] JUMP_TARGET;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK;
    logic [31:0] IMEM_RDATA;
    logic [31:0] PC_OUT;
    logic [31:0] PC_PLUS4_OUT;
    logic [31:0] INSTR_OUT;
    logic        INSTR_VALID;

    int checks   = 0;
    int failures = 0;

    if_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk          (clk),
        .rst          (rst),
        .PC_WR        (PC_WR),
        .BRANCH_TAKEN (BRANCH_TAKEN),
        .BRANCH_TARGET(BRANCH_TARGET),
        .JUMP         (JUMP),
        .JUMP_TARGET  (JUMP_TARGET),
        .IMEM_REQ     (IMEM_REQ),
        .IMEM_ADDR    (IMEM_ADDR),
        .IMEM_ACK     (IMEM_ACK),
        .IMEM_RDATA   (IMEM_RDATA),
        .PC_OUT       (PC_OUT),
        .PC_PLUS4_OUT (PC_PLUS4_OUT),
        .INSTR_OUT    (INSTR_OUT),
        .INSTR_VALID  (INSTR_VALID)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: the pending fetch is either on-path or squashed (to be
    // replaced by m_dest), and a stalled word may be parked waiting for PC_WR.
    logic [31:0] m_pc, m_dest, m_buf;
    logic        m_squash, m_have_buf;
    logic [31:0] m_pc_out, m_pc4, m_instr;
    logic        m_valid;
    logic        m_req;

    always_comb m_req = rst && !m_have_buf;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc = 32'h0000_3000; m_dest = 0; m_buf = 0;
            m_squash = 0; m_have_buf = 0;
            m_pc_out = 0; m_pc4 = 0; m_instr = 0; m_valid = 0;
        end else begin
            if (BRANCH_TAKEN || JUMP) begin
                logic [31:0] tgt;
                tgt = BRANCH_TAKEN ? BRANCH_TARGET : JUMP_TARGET;
                tgt = tgt & 32'hFFFF_FFFC;
                m_instr = 0; m_valid = 0;
                if (m_have_buf) begin
                    m_have_buf = 0; m_pc = tgt;
                end else if (IMEM_ACK) begin
                    m_squash = 0; m_pc = tgt;
                end else begin
                    m_squash = 1; m_dest = tgt;
                end
            end else if (m_have_buf) begin
                if (PC_WR) begin
                    m_instr = m_buf; m_valid = 1;
                    m_pc_out = m_pc; m_pc4 = m_pc + 4;
                    m_pc = m_pc + 4; m_have_buf = 0;
                end
            end else if (m_squash) begin
                m_instr = 0; m_valid = 0;
                if (IMEM_ACK) begin
                    m_pc = m_dest; m_squash = 0;
                end
            end else if (IMEM_ACK) begin
                if (PC_WR) begin
                    m_instr = IMEM_RDATA; m_valid = 1;
                    m_pc_out = m_pc; m_pc4 = m_pc + 4;
                    m_pc = m_pc + 4;
                end else begin
                    m_have_buf = 1; m_buf = IMEM_RDATA;
                end
            end else if (PC_WR) begin
                m_instr = 0; m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("req",   {31'd0, IMEM_REQ},    {31'd0, m_req});
        chk("addr",  IMEM_ADDR,            m_pc);
        chk("pcout", PC_OUT,               m_pc_out);
        chk("pc4",   PC_PLUS4_OUT,         m_pc4);
        chk("instr", INSTR_OUT,            m_instr);
        chk("valid", {31'd0, INSTR_VALID}, {31'd0, m_valid});
    end

    // Apply inputs just after a falling edge, let one rising edge consume them,
    // and return just past the following falling edge.
    task automatic cyc(input logic pcwr, input logic bt, input logic [31:0] bt_t,
                       input logic jp, input logic [31:0] jp_t,
                       input logic ack, input logic [31:0] rd);
        PC_WR = pcwr; BRANCH_TAKEN = bt; BRANCH_TARGET = bt_t;
        JUMP = jp; JUMP_TARGET = jp_t; IMEM_ACK = ack; IMEM_RDATA = rd;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        PC_WR = 1; BRANCH_TAKEN = 0; BRANCH_TARGET = 0;
        JUMP = 0; JUMP_TARGET = 0; IMEM_ACK = 0; IMEM_RDATA = 0;
        @(negedge clk); #1;
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst_pcout", PC_OUT, 32'h0);
        chk("rst_valid", {31'd0, INSTR_VALID}, 32'h0);
        chk("rst_instr", INSTR_OUT, 32'h0);
        chk("rst_addr",  IMEM_ADDR, 32'h3000);
        rst = 1'b1; #1;
        chk("rel_req", {31'd0, IMEM_REQ}, 32'h1);

        // Ack tied high: one instruction per cycle.
        cyc(1, 0, 0, 0, 0, 1, 32'hAAAA_0000);
        chk("s1_valid", {31'd0, INSTR_VALID}, 32'h1);
        chk("s1_pcout", PC_OUT, 32'h3000);
        chk("s1_pc4",   PC_PLUS4_OUT, 32'h3004);
        chk("s1_instr", INSTR_OUT, 32'hAAAA_0000);
        chk("s1_addr",  IMEM_ADDR, 32'h3004);
        cyc(1, 0, 0, 0, 0, 1, 32'hAAAA_0004);
        chk("s1_addr2", IMEM_ADDR, 32'h3008);

        // Slow memory: address held, bubbles in between.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
            chk("s2_addr",  IMEM_ADDR, 32'h3008);
            chk("s2_valid", {31'd0, INSTR_VALID}, 32'h0);
            chk("s2_instr", INSTR_OUT, 32'h0);
        end
        cyc(1, 0, 0, 0, 0, 1, 32'hBBBB_3008);
        chk("s2_pcout", PC_OUT, 32'h3008);
        chk("s2_instr2", INSTR_OUT, 32'hBBBB_3008);

        // Stall while the ack arrives: word parked, outputs frozen.
        cyc(0, 0, 0, 0, 0, 1, 32'hCCCC_300C);
        chk("s3_req",   {31'd0, IMEM_REQ}, 32'h0);
        chk("s3_pcout", PC_OUT, 32'h3008);
        chk("s3_instr", INSTR_OUT, 32'hBBBB_3008);
        cyc(0, 0, 0, 0, 0, 0, 32'h0);
        chk("s3_req2",  {31'd0, IMEM_REQ}, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        chk("s3_instr2", INSTR_OUT, 32'hCCCC_300C);
        chk("s3_pcout2", PC_OUT, 32'h300C);
        chk("s3_addr",   IMEM_ADDR, 32'h3010);

        // Branch while fetch pending: old data discarded.
        cyc(1, 1, 32'h3100, 0, 0, 0, 32'h0);
        chk("s4_valid", {31'd0, INSTR_VALID}, 32'h0);
        chk("s4_addr",  IMEM_ADDR, 32'h3010);
        cyc(1, 0, 0, 0, 0, 1, 32'hBAD0_3010);
        chk("s4_addr2",  IMEM_ADDR, 32'h3100);
        chk("s4_valid2", {31'd0, INSTR_VALID}, 32'h0);
        cyc(1, 0, 0, 0, 0, 1, 32'h1111_3100);
        chk("s4_pcout", PC_OUT, 32'h3100);

        // Branch+jump together under stall: branch wins, target aligned.
        cyc(0, 1, 32'h4002, 1, 32'h5000, 1, 32'hBAD0_3104);
        chk("s5_addr",  IMEM_ADDR, 32'h4000);
        chk("s5_valid", {31'd0, INSTR_VALID}, 32'h0);

        // PC wraps.
        cyc(1, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'hBAD0_4000);
        chk("s6_addr", IMEM_ADDR, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0, 0, 1, 32'h2222_FFFC);
        chk("s6_pcout", PC_OUT, 32'hFFFF_FFFC);
        chk("s6_pc4",   PC_PLUS4_OUT, 32'h0);
        chk("s6_addr2", IMEM_ADDR, 32'h0);

        // Reset mid-DROP.
        cyc(1, 1, 32'h0000_0200, 0, 0, 0, 32'h0);
        rst = 1'b0; #1;
        chk("s7_addr",  IMEM_ADDR, 32'h3000);
        chk("s7_valid", {31'd0, INSTR_VALID}, 32'h0);
        chk("s7_pcout", PC_OUT, 32'h0);
        chk("s7_req",   {31'd0, IMEM_REQ}, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 32'h0);
        rst = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic pw, bt, jp, ak;
            logic [31:0] bt_t, jp_t;
            pw   = ($urandom_range(0, 3) != 0);
            bt   = ($urandom_range(0, 19) == 0);
            jp   = ($urandom_range(0, 19) == 0);
            bt_t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
            jp_t = $urandom;
            ak   = m_req && ($urandom_range(0, 9) < 6);
            cyc(pw, bt, bt_t, jp, jp_t, ak, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC and issues single-outstanding requests to instruction memory over a req/ack handshake.
- Applies hazard stalls and branch/jump redirects from ID, with redirects flushing wrong-path fetches.
- Presents INSTR_OUT / PC_PLUS4_OUT to IF/ID; empty slots are shown as zero (nop) bubbles.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded at reset; bits [1:0] must be 0.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset (0 = reset)
PC_WR  in  1  1 = pipeline advances; 0 = hazard stall, hold PC and outputs
BRANCH_TAKEN  in  1  one-cycle redirect pulse from ID
BRANCH_TARGET  in  32  branch target address
JUMP  in  1  one-cycle redirect pulse from ID
JUMP_TARGET  in  32  jump target address
IMEM_REQ  out  1  fetch request
IMEM_ADDR  out  32  fetch word address (= internal pc)
IMEM_ACK  in  1  data valid; legal only while IMEM_REQ=1; may arrive in the same cycle as REQ
IMEM_RDATA  in  32  fetched instruction, sampled when IMEM_ACK=1
PC_OUT  out  32  address of INSTR_OUT
PC_PLUS4_OUT  out  32  PC_OUT+4, feeds IF/ID
INSTR_OUT  out  32  fetched instruction; 0 when bubble
INSTR_VALID  out  1  1 = INSTR_OUT is a real instruction

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, state=FETCH, redir_pc=0, buf=0. PC_OUT, PC_PLUS4_OUT and INSTR_OUT are 0; INSTR_VALID=0. The first request issues in the first cycle after release.
- All outputs except IMEM_REQ/IMEM_ADDR are registered. IMEM_REQ=1 in states FETCH and DROP, 0 in HOLD. IMEM_ADDR=pc at all times.
- pc never changes while IMEM_REQ=1 and no ack has been received, so the address stays stable for the whole handshake.
- Redirect target: BRANCH_TAKEN has priority over JUMP. Bits [1:0] of the target are forced to 0.
- A redirect overrides PC_WR=0.
- States: FETCH, HOLD, DROP. Per-cycle priority:
  1. Redirect asserted. Outputs become a bubble (INSTR_OUT=0, VALID=0; PC_OUT and PC_PLUS4_OUT unchanged).
     - FETCH without ack: redir_pc<=target, go to DROP.
     - FETCH with ack: discard IMEM_RDATA, pc<=target, stay in FETCH.
     - HOLD: discard buf, pc<=target, go to FETCH.
     - DROP without ack: redir_pc<=target (newest redirect wins), stay in DROP.
     - DROP with ack: pc<=target, go to FETCH.
  2. FETCH, ack, PC_WR=1: INSTR_OUT<=IMEM_RDATA, PC_OUT<=pc, PC_PLUS4_OUT<=pc+4, VALID<=1, pc<=pc+4. Stay in FETCH. Back-to-back acks sustain 1 instruction/cycle.
  3. FETCH, ack, PC_WR=0: buf<=IMEM_RDATA, go to HOLD. Outputs unchanged.
  4. FETCH, no ack: if PC_WR=1, outputs become a bubble; if PC_WR=0, outputs hold.
  5. HOLD, PC_WR=1: INSTR_OUT<=buf, PC_OUT<=pc, PC_PLUS4_OUT<=pc+4, VALID<=1, pc<=pc+4, go to FETCH.
  6. HOLD, PC_WR=0: everything holds.
  7. DROP, no redirect: IMEM_REQ stays 1 at the old pc. On ack, data is discarded, pc<=redir_pc, go to FETCH. Outputs stay a bubble throughout.
- No branch delay slot: the instruction fetched after a branch is always squashed.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0); no overflow flag.
- Reset asserted mid-handshake abandons the request. The memory must tolerate IMEM_REQ dropping without an ack.

Test Plan:
- Reset release with ack tied to 1 → IMEM_ADDR reads 3000, 3004, 3008 on consecutive cycles. First edge after release: INSTR_VALID=1, PC_OUT=3000, PC_PLUS4_OUT=3004.
- Ack delayed 3 cycles per fetch → IMEM_ADDR holds 3000 for 4 cycles. Bubbles (INSTR_OUT=0, VALID=0) appear between instructions.
- PC_WR=0 for 2 cycles while ack arrives → state enters HOLD, IMEM_REQ=0, outputs frozen. On PC_WR=1 the buffered word appears with PC_OUT=pc, then fetch resumes at pc+4.
- BRANCH_TAKEN=1, target 0x3100, while fetch of 0x3008 is pending → DROP. 0x3008 data is discarded, next IMEM_ADDR=0x3100, no wrong-path VALID.
- BRANCH_TAKEN and JUMP asserted together (branch 0x4000, jump 0x5000), then PC_WR=0 in the same cycle → redirect to 0x4000 still taken. Target 0x4002 is fetched as 0x4000.
- PC=32'hFFFF_FFFC fetched → PC_PLUS4_OUT=0, next IMEM_ADDR=0. Reset asserted mid-DROP → pc=RESET_PC, VALID=0 immediately.
